register_file: RTL and testbench

//  32x32-bit MIPS general-purpose register file, directly upstream of the ALU.
//  Two combinational read ports supply the ALU a_i/b_i operands; one synchronous

---
 rtl/register_file_if.sv | 42 ++++
 rtl/register_file.sv | 70 +++++++
 tb/tb_register_file.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file access bus: one write port, two operand read ports and a debug read port.
// The master side (datapath) drives indices and write data; the slave side (register file) returns read data.
interface register_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  reg_write_i;
  logic [ADDR_WIDTH-1:0] write_register_i;
  logic [DATA_WIDTH-1:0] write_data_i;
  logic [ADDR_WIDTH-1:0] read_register_1_i;
  logic [ADDR_WIDTH-1:0] read_register_2_i;
  logic [ADDR_WIDTH-1:0] dbg_register_i;
  logic [DATA_WIDTH-1:0] read_data_1_o;
  logic [DATA_WIDTH-1:0] read_data_2_o;
  logic [DATA_WIDTH-1:0] dbg_data_o;

  modport master (
    output reg_write_i,
    output write_register_i,
    output write_data_i,
    output read_register_1_i,
    output read_register_2_i,
    output dbg_register_i,
    input  read_data_1_o,
    input  read_data_2_o,
    input  dbg_data_o
  );

  modport slave (
    input  reg_write_i,
    input  write_register_i,
    input  write_data_i,
    input  read_register_1_i,
    input  read_register_2_i,
    input  dbg_register_i,
    output read_data_1_o,
    output read_data_2_o,
    output dbg_data_o
  );

endinterface

// File: rtl/register_file.sv
// MIPS general-purpose register file: $0 hardwired to zero, two combinational operand
// read ports, one synchronous write port and a non-bypassing debug read port.
module register_file #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = DATA_WIDTH'(32'h7FFF_EFFC),
  parameter logic [DATA_WIDTH-1:0] GP_RESET   = DATA_WIDTH'(32'h1000_8000),
  parameter int unsigned           BYPASS     = 0
) (
  input logic            clk,
  input logic            reset,
  register_file_if.slave rf
);

  localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int unsigned GP_INDEX  = 28;
  localparam int unsigned SP_INDEX  = 29;
  localparam bit          BYPASS_EN = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  write_en;
  logic                  hit_1;
  logic                  hit_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic [DATA_WIDTH-1:0] dbg_data;

  // Power-up contents: everything zero except the ABI global and stack pointers.
  function automatic logic [DATA_WIDTH-1:0] reset_value(input int unsigned idx);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (idx == GP_INDEX) val = GP_RESET;
    if (idx == SP_INDEX) val = SP_RESET;
    return val;
  endfunction

  // Writes to $0 are dropped so the storage for index 0 stays zero forever.
  assign write_en = rf.reg_write_i && (rf.write_register_i != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[ADDR_WIDTH'(i)] <= reset_value(i);
      end
    end else if (write_en) begin
      regs[rf.write_register_i] <= rf.write_data_i;
    end
  end

  // Same-cycle forwarding of the writeback value, only when the bypass option is built in.
  assign hit_1 = BYPASS_EN && write_en && (rf.write_register_i == rf.read_register_1_i);
  assign hit_2 = BYPASS_EN && write_en && (rf.write_register_i == rf.read_register_2_i);

  always_comb begin
    read_data_1 = regs[rf.read_register_1_i];
    read_data_2 = regs[rf.read_register_2_i];
    dbg_data    = regs[rf.dbg_register_i];
    if (hit_1) read_data_1 = rf.write_data_i;
    if (hit_2) read_data_2 = rf.write_data_i;
    if (rf.read_register_1_i == '0) read_data_1 = '0;
    if (rf.read_register_2_i == '0) read_data_2 = '0;
    if (rf.dbg_register_i == '0) dbg_data = '0;
  end

  assign rf.read_data_1_o = read_data_1;
  assign rf.read_data_2_o = read_data_2;
  assign rf.dbg_data_o    = dbg_data;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance without and one with write-to-read bypass,
// both driven with identical stimulus and checked against hand-computed values.
module tb_register_file;

  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_VAL = 32'h1000_8000;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_nb ();
  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_by ();

  register_file #(.BYPASS(0)) u_nb (.clk(clk), .reset(reset), .rf(bus_nb));
  register_file #(.BYPASS(1)) u_by (.clk(clk), .reset(reset), .rf(bus_by));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Same stimulus to both instances.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    bus_nb.reg_write_i = we;  bus_by.reg_write_i = we;
    bus_nb.write_register_i = wa;  bus_by.write_register_i = wa;
    bus_nb.write_data_i = wd;  bus_by.write_data_i = wd;
    bus_nb.read_register_1_i = r1;  bus_by.read_register_1_i = r1;
    bus_nb.read_register_2_i = r2;  bus_by.read_register_2_i = r2;
    bus_nb.dbg_register_i = dbg;  bus_by.dbg_register_i = dbg;
  endtask

  // Present a write, take one edge, then deassert the enable.
  task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
    drive(1'b1, wa, wd, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset contents on every register through the debug port.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'(i));
      #1;
      exp = (i == 28) ? GP_VAL : (i == 29) ? SP_VAL : 32'h0;
      check($sformatf("rst_dbg_nb[%0d]", i), bus_nb.dbg_data_o, exp);
      check($sformatf("rst_dbg_by[%0d]", i), bus_by.dbg_data_o, exp);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd28, 5'd29, 5'd0);
    #1;
    check("rst_rd1_gp", bus_nb.read_data_1_o, GP_VAL);
    check("rst_rd2_sp", bus_nb.read_data_2_o, SP_VAL);

    // Write then read the same register on both operand ports.
    write_reg(5'd8, 32'hDEAD_BEEF);
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);
    #1;
    check("wr8_rd1", bus_nb.read_data_1_o, 32'hDEAD_BEEF);
    check("wr8_rd2", bus_nb.read_data_2_o, 32'hDEAD_BEEF);
    check("wr8_dbg", bus_by.dbg_data_o, 32'hDEAD_BEEF);

    // $0 discards writes.
    write_reg(5'd0, 32'h1234_5678);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("r0_rd1", bus_nb.read_data_1_o, 32'h0);
    check("r0_rd2", bus_by.read_data_2_o, 32'h0);
    check("r0_dbg", bus_nb.dbg_data_o, 32'h0);

    // Distinct registers on the two read ports.
    write_reg(5'd1, 32'h1111_0001);
    write_reg(5'd2, 32'h2222_0002);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd0);
    #1;
    check("pair_rd1", bus_nb.read_data_1_o, 32'h1111_0001);
    check("pair_rd2", bus_nb.read_data_2_o, 32'h2222_0002);

    // Collision: old value without bypass, new value with bypass; debug never bypasses.
    drive(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
    #1;
    check("coll_pre_nb_rd1", bus_nb.read_data_1_o, 32'h0);
    check("coll_pre_nb_rd2", bus_nb.read_data_2_o, 32'h0);
    check("coll_pre_by_rd1", bus_by.read_data_1_o, 32'hA5A5_A5A5);
    check("coll_pre_by_rd2", bus_by.read_data_2_o, 32'hA5A5_A5A5);
    check("coll_pre_by_dbg", bus_by.dbg_data_o, 32'h0);
    @(posedge clk);
    #1;
    bus_nb.reg_write_i = 1'b0;
    bus_by.reg_write_i = 1'b0;
    #1;
    check("coll_post_nb_rd1", bus_nb.read_data_1_o, 32'hA5A5_A5A5);
    check("coll_post_by_rd1", bus_by.read_data_1_o, 32'hA5A5_A5A5);
    check("coll_post_nb_dbg", bus_nb.dbg_data_o, 32'hA5A5_A5A5);

    // Bypass with index 0 still reads zero.
    drive(1'b1, 5'd0, 32'hCAFE_F00D, 5'd0, 5'd0, 5'd0);
    #1;
    check("byp_r0_rd1", bus_by.read_data_1_o, 32'h0);
    @(posedge clk);
    #1;

    // Write enable low: no change.
    drive(1'b0, 5'd10, 32'hFFFF_FFFF, 5'd10, 5'd0, 5'd10);
    @(posedge clk);
    #1;
    check("nowe_rd1", bus_nb.read_data_1_o, 32'h0);
    check("nowe_dbg", bus_by.dbg_data_o, 32'h0);

    // Reset beats a simultaneous write and restores power-up state mid-program.
    reset = 1'b1;
    drive(1'b1, 5'd29, 32'h5, 5'd29, 5'd8, 5'd9);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd8, 5'd9);
    #1;
    check("rstwr_sp_nb", bus_nb.read_data_1_o, SP_VAL);
    check("rstwr_sp_by", bus_by.read_data_1_o, SP_VAL);
    check("rstwr_r8", bus_nb.read_data_2_o, 32'h0);
    check("rstwr_r9", bus_nb.dbg_data_o, 32'h0);

    // JAL link value into $31, observed on the debug port.
    write_reg(5'd31, 32'h0040_0008);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd28, 5'd31);
    #1;
    check("jal_dbg_nb", bus_nb.dbg_data_o, 32'h0040_0008);
    check("jal_dbg_by", bus_by.dbg_data_o, 32'h0040_0008);
    check("jal_rd1", bus_nb.read_data_1_o, 32'h0040_0008);
    check("jal_gp", bus_nb.read_data_2_o, GP_VAL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
